eight_bit_adder_modify_module: RTL and testbench

EIGHT_BIT_ADDER_MODIFY_MODULE -- requirements
Module: eight_bit_adder_modify_module

---
 rtl/eight_bit_adder_modify_module.sv | 80 ++++++++
 tb/tb_eight_bit_adder_modify_module.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/eight_bit_adder_modify_module.sv
// eight_bit_adder_modify_module
// Registered 8-bit unsigned adder built as a carry-select adder: the low
// nibble ripples from carry-in 0, the high nibble is computed twice (carry-in
// 0 and 1) and the low-nibble carry picks one. The 9-bit result is captured
// every rising clock edge and cleared asynchronously while rst_n is low.
//
// Ports:
//   clk   in   1  clock, rising edge
//   rst_n in   1  asynchronous active-low reset
//   a     in   8  unsigned operand A
//   b     in   8  unsigned operand B
//   sum   out  8  registered low 8 bits of a+b
//   cout  out  1  registered carry-out of a+b
module eight_bit_adder_modify_module (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic [7:0] sum,
    output logic       cout
);

    localparam int unsigned DATA_W = 8;
    localparam int unsigned NIB_W  = 4;

    // 4-bit ripple chain of full adders; returns {carry_out, sum[3:0]}.
    function automatic logic [NIB_W:0] ripple4(
        input logic [NIB_W-1:0] x,
        input logic [NIB_W-1:0] y,
        input logic             ci
    );
        logic [NIB_W-1:0] s;
        logic             c;
        c = ci;
        s = '0;
        for (int i = 0; i < int'(NIB_W); i++) begin
            s[i] = x[i] ^ y[i] ^ c;
            c    = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
        end
        return {c, s};
    endfunction

    logic [NIB_W:0]  lo_res;
    logic [NIB_W:0]  hi_res0;
    logic [NIB_W:0]  hi_res1;
    logic [NIB_W:0]  hi_sel;
    logic            c4;

    logic [DATA_W-1:0] sum_d;
    logic [DATA_W-1:0] sum_q;
    logic              cout_d;
    logic              cout_q;

    // Carry-select datapath: both high-nibble candidates are formed in
    // parallel with the low nibble, c4 only drives the final mux.
    always_comb begin
        lo_res  = ripple4(a[NIB_W-1:0], b[NIB_W-1:0], 1'b0);
        hi_res0 = ripple4(a[DATA_W-1:NIB_W], b[DATA_W-1:NIB_W], 1'b0);
        hi_res1 = ripple4(a[DATA_W-1:NIB_W], b[DATA_W-1:NIB_W], 1'b1);
        c4      = lo_res[NIB_W];
        hi_sel  = c4 ? hi_res1 : hi_res0;
        sum_d   = {hi_sel[NIB_W-1:0], lo_res[NIB_W-1:0]};
        cout_d  = hi_sel[NIB_W];
    end

    // Result register: loads every edge, no enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q  <= '0;
            cout_q <= 1'b0;
        end else begin
            sum_q  <= sum_d;
            cout_q <= cout_d;
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_eight_bit_adder_modify_module.sv
// tb_eight_bit_adder_modify_module
// Self-checking bench for the registered 8-bit adder. Inputs are driven on
// the falling edge; outputs are sampled 1 ns after the rising edge. Expected
// results come from plain 9-bit arithmetic on the applied operands.
module tb_eight_bit_adder_modify_module;

    logic       clk;
    logic       rst_n;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] sum;
    logic       cout;

    int checks;
    int errors;

    eight_bit_adder_modify_module dut (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (a),
        .b     (b),
        .sum   (sum),
        .cout  (cout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [8:0] ref_add(input logic [7:0] x, input logic [7:0] y);
        int unsigned total;
        total = int'(x) + int'(y);
        return 9'(total % 512);
    endfunction

    task automatic check(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed {cout,sum}=%h expected %h", tag, obs, exp);
        end
    endtask

    // Drive a pair on the falling edge, check it one edge later.
    task automatic apply(input logic [7:0] x, input logic [7:0] y,
                         input logic [8:0] exp, input string tag);
        @(negedge clk);
        a = x;
        b = y;
        @(posedge clk);
        #1;
        check(tag, {cout, sum}, exp);
    endtask

    initial begin
        logic [7:0] ra;
        logic [7:0] rb;
        logic [8:0] held;
        checks = 0;
        errors = 0;

        // Held in reset with operands present and clock running.
        rst_n = 1'b0;
        a     = 8'hAA;
        b     = 8'h55;
        #1;
        check("reset_initial", {cout, sum}, 9'h000);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("reset_hold_pos", {cout, sum}, 9'h000);
            @(negedge clk);
            #1;
            check("reset_hold_neg", {cout, sum}, 9'h000);
        end
        rst_n = 1'b1;
        #1;
        check("release_no_edge", {cout, sum}, 9'h000);
        @(posedge clk);
        #1;
        check("release_first_edge", {cout, sum}, 9'h0FF);

        // Carry-select paths and extremes.
        apply(8'h0F, 8'h01, 9'h010, "nibble_carry");
        apply(8'hF0, 8'h10, 9'h100, "hi_carry_out");
        apply(8'h8F, 8'h71, 9'h100, "both_carries");
        apply(8'hFF, 8'h01, 9'h100, "overflow");
        apply(8'hFF, 8'hFF, 9'h1FE, "maximum");
        apply(8'h00, 8'h00, 9'h000, "zero");

        // Input changes between edges must not reach the outputs.
        apply(8'h12, 8'h34, 9'h046, "glitch_base");
        held = {cout, sum};
        a = 8'hFF; b = 8'hFF;
        #1;
        check("glitch_1", {cout, sum}, held);
        a = 8'h80; b = 8'h80;
        #1;
        check("glitch_2", {cout, sum}, held);
        a = 8'h21; b = 8'h43;
        @(posedge clk);
        #1;
        check("glitch_edge", {cout, sum}, 9'h064);

        // Asynchronous reset between edges, mid-operation.
        apply(8'h7F, 8'h00, 9'h07F, "pre_reset_7f");
        @(negedge clk);
        a = 8'h3C; b = 8'hC4;
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_reset_clear", {cout, sum}, 9'h000);
        #1;
        rst_n = 1'b1;
        #1;
        check("mid_reset_hold", {cout, sum}, 9'h000);
        @(posedge clk);
        #1;
        check("mid_reset_reload", {cout, sum}, 9'h100);

        // Randomized pairs against the arithmetic model.
        for (int i = 0; i < 300; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            apply(ra, rb, ref_add(ra, rb), "random");
        end

        // Exhaustive sweep, one pair per clock.
        for (int i = 0; i < 65536; i++) begin
            ra = 8'(i >> 8);
            rb = 8'(i);
            apply(ra, rb, ref_add(ra, rb), "sweep");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
